// File: rtl/implication_queue.sv
// Implication queue: buffers BCP implications, filters duplicates and redundant
// assignments against the trail, detects conflicts, and forwards pushes to the trail.
module implication_queue #(
  parameter int MAX_VARS = 256,
  parameter int DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  int                           DEBUG,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_var,
  input  logic                         in_value,
  input  logic [15:0]                  in_level,
  input  logic [15:0]                  in_reason,
  input  logic                         dec_valid,
  output logic                         dec_ready,
  input  logic [31:0]                  dec_var,
  input  logic                         dec_value,
  input  logic [15:0]                  dec_level,
  input  logic                         trail_busy,
  output logic [31:0]                  q_var,
  input  logic                         q_valid,
  input  logic                         q_value,
  input  logic [15:0]                  q_reason,
  output logic                         push,
  output logic [31:0]                  push_var,
  output logic                         push_value,
  output logic [15:0]                  push_level,
  output logic                         push_is_decision,
  output logic [15:0]                  push_reason,
  output logic                         conflict_valid,
  output logic [31:0]                  conflict_var,
  output logic [15:0]                  conflict_reason,
  output logic [15:0]                  conflict_other_reason,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  dup_count
);

  localparam int IW = $clog2(MAX_VARS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]         varMem_q [DEPTH];
  logic                valMem_q [DEPTH];
  logic [15:0]         lvlMem_q [DEPTH];
  logic [15:0]         rsnMem_q [DEPTH];

  logic [PW-1:0]       rdPtr_q, wrPtr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [MAX_VARS-1:0] pending_q, pval_q;
  logic                conflict_q;
  logic [31:0]         confVar_q;
  logic [15:0]         confRsn_q, confOther_q;
  logic [15:0]         dup_q, dup_d;
  logic [16:0]         dupSum;

  logic [31:0] headVar;
  logic        headVal;
  logic [15:0] headLvl, headRsn;
  logic [IW-1:0] inIdx, headIdx;
  logic inPending, inPval;
  logic enqFire, enqWrite, enqDup, enqConf;
  logic service, headPush, headRedund, headConf, pop, decFire;
  logic unusedBits;

  assign headVar = varMem_q[rdPtr_q];
  assign headVal = valMem_q[rdPtr_q];
  assign headLvl = lvlMem_q[rdPtr_q];
  assign headRsn = rsnMem_q[rdPtr_q];
  assign inIdx   = in_var[IW-1:0];
  assign headIdx = headVar[IW-1:0];

  assign q_var     = headVar;
  assign in_ready  = (count_q < FULL) && !conflict_q && !flush;
  assign dec_ready = (count_q == '0) && !in_valid && !trail_busy && !conflict_q && !flush;

  // Pending state is looked up before any same-cycle pop clears it
  assign inPending = pending_q[inIdx];
  assign inPval    = pval_q[inIdx];
  assign enqFire   = in_valid && in_ready;
  assign enqWrite  = enqFire && !inPending;
  assign enqDup    = enqFire && inPending && (inPval == in_value);
  assign enqConf   = enqFire && inPending && (inPval != in_value);

  assign service    = (count_q != '0) && !trail_busy && !conflict_q && !flush;
  assign headPush   = service && !q_valid;
  assign headRedund = service && q_valid && (q_value == headVal);
  assign headConf   = service && q_valid && (q_value != headVal);
  assign pop        = headPush || headRedund;
  assign decFire    = dec_valid && dec_ready;

  assign count_d = count_q + CW'(enqWrite) - CW'(pop);
  assign dupSum  = {1'b0, dup_q} + 17'(enqDup) + 17'(headRedund);
  assign dup_d   = dupSum[16] ? 16'hFFFF : dupSum[15:0];

  assign unusedBits = ^{DEBUG, in_var[31:IW]};

  always_comb begin
    push             = 1'b0;
    push_var         = '0;
    push_value       = 1'b0;
    push_level       = '0;
    push_is_decision = 1'b0;
    push_reason      = '0;
    if (headPush) begin
      push        = 1'b1;
      push_var    = headVar;
      push_value  = headVal;
      push_level  = headLvl;
      push_reason = headRsn;
    end else if (decFire) begin
      push             = 1'b1;
      push_var         = dec_var;
      push_value       = dec_value;
      push_level       = dec_level;
      push_is_decision = 1'b1;
      push_reason      = 16'hFFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (enqWrite) begin
      varMem_q[wrPtr_q] <= in_var;
      valMem_q[wrPtr_q] <= in_value;
      lvlMem_q[wrPtr_q] <= in_level;
      rsnMem_q[wrPtr_q] <= in_reason;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      pval_q      <= '0;
      conflict_q  <= 1'b0;
      confVar_q   <= '0;
      confRsn_q   <= '0;
      confOther_q <= '0;
      dup_q       <= '0;
    end else begin
      dup_q <= dup_d;
      if (flush) begin
        rdPtr_q     <= '0;
        wrPtr_q     <= '0;
        count_q     <= '0;
        pending_q   <= '0;
        pval_q      <= '0;
        conflict_q  <= 1'b0;
        confVar_q   <= '0;
        confRsn_q   <= '0;
        confOther_q <= '0;
      end else begin
        count_q <= count_d;
        if (pop) begin
          rdPtr_q            <= rdPtr_q + 1'b1;
          pending_q[headIdx] <= 1'b0;
        end
        if (enqWrite) begin
          wrPtr_q          <= wrPtr_q + 1'b1;
          pending_q[inIdx] <= 1'b1;
          pval_q[inIdx]    <= in_value;
        end
        // Enqueue-side conflict takes the capture when both fire together
        if (enqConf) begin
          conflict_q  <= 1'b1;
          confVar_q   <= in_var;
          confRsn_q   <= in_reason;
          confOther_q <= 16'hFFFF;
        end else if (headConf) begin
          conflict_q  <= 1'b1;
          confVar_q   <= headVar;
          confRsn_q   <= headRsn;
          confOther_q <= q_reason;
        end
      end
    end
  end

  assign conflict_valid        = conflict_q;
  assign conflict_var          = confVar_q;
  assign conflict_reason       = confRsn_q;
  assign conflict_other_reason = confOther_q;
  assign count                 = count_q;
  assign dup_count             = dup_q;

  always @(posedge clk) begin
    if (!reset && enqFire) assert (in_var < 32'(MAX_VARS));
    if (!reset && decFire) assert (dec_var < 32'(MAX_VARS));
  end

endmodule
